// File: rtl/fpu_add_issue.sv
// rtl/fpu_add_issue.sv - FADD.S/FSUB.S operand issue stage with special-case classification and 2-entry buffer
module fpu_add_issue #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_special,
    output logic [31:0]      out_special_val,
    output logic             out_nv
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [1:0]       count;
    logic             rd_ptr;
    logic             wr_ptr;
    logic [31:0]      mem_a   [2];
    logic [31:0]      mem_b   [2];
    logic [31:0]      mem_val [2];
    logic [TAG_W-1:0] mem_tag [2];
    logic             mem_sp  [2];
    logic             mem_nv  [2];

    logic        push;
    logic        pop;
    logic [31:0] b_eff;
    logic        a_nan, a_snan, a_inf, a_zero;
    logic        b_nan, b_snan, b_inf, b_zero;
    logic        c_special;
    logic [31:0] c_val;
    logic        c_nv;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign b_eff  = {in_b[31] ^ in_op, in_b[30:0]};
    assign a_nan  = (&in_a[30:23]) && (|in_a[22:0]);
    assign a_snan = a_nan && !in_a[22];
    assign a_inf  = (&in_a[30:23]) && !(|in_a[22:0]);
    assign a_zero = !(|in_a[30:0]);
    assign b_nan  = (&in_b[30:23]) && (|in_b[22:0]);
    assign b_snan = b_nan && !in_b[22];
    assign b_inf  = (&in_b[30:23]) && !(|in_b[22:0]);
    assign b_zero = !(|in_b[30:0]);

    // First matching rule wins; the sign comparisons use the already-flipped B.
    always_comb begin
        c_special = 1'b1;
        c_val     = 32'h0;
        c_nv      = 1'b0;
        if (a_nan || b_nan) begin
            c_val = QNAN;
            c_nv  = a_snan || b_snan;
        end else if (a_inf && b_inf && (in_a[31] != b_eff[31])) begin
            c_val = QNAN;
            c_nv  = 1'b1;
        end else if (a_inf) begin
            c_val = in_a;
        end else if (b_inf) begin
            c_val = b_eff;
        end else if (a_zero && b_zero) begin
            c_val = {in_a[31] & b_eff[31], 31'b0};
        end else if (a_zero) begin
            c_val = b_eff;
        end else if (b_zero) begin
            c_val = in_a;
        end else begin
            c_special = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_a[i]   <= 32'h0;
                mem_b[i]   <= 32'h0;
                mem_val[i] <= 32'h0;
                mem_tag[i] <= '0;
                mem_sp[i]  <= 1'b0;
                mem_nv[i]  <= 1'b0;
            end
        end else if (flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem_a[wr_ptr]   <= in_a;
                mem_b[wr_ptr]   <= b_eff;
                mem_val[wr_ptr] <= c_val;
                mem_tag[wr_ptr] <= in_tag;
                mem_sp[wr_ptr]  <= c_special;
                mem_nv[wr_ptr]  <= c_nv;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign out_a           = mem_a[rd_ptr];
    assign out_b           = mem_b[rd_ptr];
    assign out_tag         = mem_tag[rd_ptr];
    assign out_special     = mem_sp[rd_ptr];
    assign out_special_val = mem_val[rd_ptr];
    assign out_nv          = mem_nv[rd_ptr];
endmodule
